// File: rtl/unpacked_serializer_if.sv
// Array bundle between the producer and the serializer.
// C is the read-only consumer view, P the producer view.
interface I;
  logic x [7:0];

  modport C (input x);
  modport P (output x);
endinterface

// File: rtl/unpacked_serializer.sv
// Snapshots an 8-entry array on start and streams it out one bit per
// valid/ready transfer, also reporting the snapshot's popcount.
module unpacked_serializer #(
  parameter logic LSB_FIRST = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  I.C                c,
  input  logic       i_start,
  input  logic       i_ready,
  output logic       o_valid,
  output logic       o_data,
  output logic       o_last,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_popcnt
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t     state, state_nx;
  logic [7:0] snap, snap_nx;
  logic [2:0] idx, idx_nx;
  logic [3:0] pop_nx;
  logic       done_nx;
  logic [7:0] x_flat;
  logic [3:0] x_ones;
  logic [2:0] sel;
  logic       xfer;

  always_comb begin
    x_flat = '0;
    x_ones = '0;
    for (int i = 0; i < 8; i++) begin
      x_flat[i] = c.x[i];
      x_ones    = x_ones + 4'(c.x[i]);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      snap     <= '0;
      idx      <= '0;
      o_popcnt <= '0;
      o_done   <= 1'b0;
    end else begin
      snap     <= snap_nx;
      idx      <= idx_nx;
      o_popcnt <= pop_nx;
      o_done   <= done_nx;
    end
  end

  assign xfer = (state == SHIFT) && i_ready;

  always_comb begin
    state_nx = state;
    snap_nx  = snap;
    idx_nx   = idx;
    pop_nx   = o_popcnt;
    done_nx  = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_start) begin
          snap_nx  = x_flat;
          pop_nx   = x_ones;
          idx_nx   = '0;
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (xfer) begin
          if (idx == 3'd7) begin
            idx_nx   = '0;
            done_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            idx_nx = idx + 3'd1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // 7-idx on a 3-bit index is its bitwise complement
  assign sel = LSB_FIRST ? idx : ~idx;

  always_comb begin
    o_valid = 1'b0;
    o_busy  = 1'b0;
    o_last  = 1'b0;
    o_data  = 1'b0;
    unique case (state)
      IDLE: ;
      SHIFT: begin
        o_valid = 1'b1;
        o_busy  = 1'b1;
        o_last  = (idx == 3'd7);
        o_data  = snap[sel];
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_unpacked_serializer.sv
// Directed bench for unpacked_serializer with a queue-based reference
// model checking both bit orders on every cycle.
module tb_unpacked_serializer;

  logic       clk;
  logic       arst_n;
  logic       start;
  logic       ready;
  logic       v1, d1, l1, b1, dn1;
  logic       v0, d0, l0, b0, dn0;
  logic [3:0] p1, p0;

  int checks = 0;
  int failures = 0;

  I u_I ();

  unpacked_serializer #(.LSB_FIRST(1'b1)) u_lsb (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .c        (u_I.C),
    .i_start  (start),
    .i_ready  (ready),
    .o_valid  (v1),
    .o_data   (d1),
    .o_last   (l1),
    .o_busy   (b1),
    .o_done   (dn1),
    .o_popcnt (p1)
  );

  unpacked_serializer #(.LSB_FIRST(1'b0)) u_msb (
    .i_clk    (clk),
    .i_arst_n (arst_n),
    .c        (u_I.C),
    .i_start  (start),
    .i_ready  (ready),
    .o_valid  (v0),
    .o_data   (d0),
    .o_last   (l0),
    .o_busy   (b0),
    .o_done   (dn0),
    .o_popcnt (p0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic       m_busy = 1'b0;
  logic       m_done = 1'b0;
  logic [3:0] m_pop = '0;
  logic       q1[$];
  logic       q0[$];
  int         n_done = 0;
  int         n_xfer = 0;

  always @(negedge clk) begin
    logic       was_busy;
    logic       nd;
    logic [3:0] cnt;
    if (!arst_n) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_pop  = '0;
      q1.delete();
      q0.delete();
    end
    chk("valid", 8'(v1), 8'(m_busy));
    chk("valid_msb", 8'(v0), 8'(m_busy));
    chk("busy", 8'(b1), 8'(m_busy));
    chk("done", 8'(dn1), 8'(m_done));
    chk("done_msb", 8'(dn0), 8'(m_done));
    chk("popcnt", 8'(p1), 8'(m_pop));
    chk("popcnt_msb", 8'(p0), 8'(m_pop));
    if (!m_busy) begin
      chk("last_idle", 8'(l1), 8'd0);
    end else if (q1.size() > 0) begin
      chk("data_lsb", 8'(d1), 8'(q1[0]));
      chk("data_msb", 8'(d0), 8'(q0[0]));
      chk("last", 8'(l1), 8'(q1.size() == 1));
      chk("last_msb", 8'(l0), 8'(q0.size() == 1));
    end
    if (dn1) n_done++;
    if (arst_n) begin
      was_busy = m_busy;
      nd = 1'b0;
      if (was_busy && ready) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
        n_xfer++;
        if (q1.size() == 0) begin
          m_busy = 1'b0;
          nd = 1'b1;
        end
      end
      if (!was_busy && start) begin
        cnt = '0;
        for (int i = 0; i < 8; i++) begin
          q1.push_back(u_I.x[i]);
          q0.push_back(u_I.x[7-i]);
          cnt = cnt + 4'(u_I.x[i]);
        end
        m_pop  = cnt;
        m_busy = 1'b1;
      end
      m_done = nd;
    end
  end

  task automatic set_x(input logic [7:0] v);
    for (int i = 0; i < 8; i++) u_I.x[i] = v[i];
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int d0c;
    int x0c;
    arst_n = 1'b0;
    start  = 1'b0;
    ready  = 1'b1;
    set_x(8'h00);
    tick(3);
    arst_n = 1'b1;
    tick(2);

    // frame 1: x[7..0]=1011_0010, ready high
    d0c = n_done;
    x0c = n_xfer;
    set_x(8'b1011_0010);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    set_x(8'h00);
    tick(8);
    chk("f1_done_t9", 8'(dn1), 8'd1);
    chk("f1_pop", 8'(p1), 8'd4);
    tick(2);
    chk("f1_ndone", 8'(n_done - d0c), 8'd1);
    chk("f1_nxfer", 8'(n_xfer - x0c), 8'd8);

    // frame 2: all ones, stall in cycles t+2..t+4
    d0c = n_done;
    set_x(8'hFF);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(1);
    ready = 1'b0;
    tick(3);
    ready = 1'b1;
    tick(6);
    chk("f2_no_done_t11", 8'(dn1), 8'd0);
    tick(1);
    chk("f2_done_t12", 8'(dn1), 8'd1);
    chk("f2_pop", 8'(p1), 8'd8);
    tick(1);

    // frame 3: input changes and a start during SHIFT are ignored
    set_x(8'b0110_1001);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    set_x(8'h00);
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("f3_pop", 8'(p1), 8'd4);
    // cycle t+9: done high, new start captures zeros
    chk("f3_done", 8'(dn1), 8'd1);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    chk("f4_pop", 8'(p1), 8'd0);
    tick(9);

    // reset in cycle t+4 of a frame
    d0c = n_done;
    set_x(8'b1100_0101);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(3);
    arst_n = 1'b0;
    #1;
    chk("rst_valid", 8'(v1), 8'd0);
    chk("rst_busy", 8'(b1), 8'd0);
    chk("rst_data", 8'(d1), 8'd0);
    chk("rst_last", 8'(l1), 8'd0);
    chk("rst_pop", 8'(p1), 8'd0);
    tick(2);
    arst_n = 1'b1;
    tick(3);
    chk("rst_no_done", 8'(n_done - d0c), 8'd0);
    x0c = n_xfer;
    set_x(8'b0011_1010);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(9);
    chk("rst_fresh_nxfer", 8'(n_xfer - x0c), 8'd8);
    chk("rst_fresh_pop", 8'(p1), 8'd4);

    // back-to-back frames with start held high
    d0c = n_done;
    x0c = n_xfer;
    set_x(8'b1010_0111);
    start = 1'b1;
    tick(9);
    chk("b2b_idle_gap", 8'(v1), 8'd0);
    set_x(8'b0001_0000);
    tick(1);
    start = 1'b0;
    tick(9);
    chk("b2b_ndone", 8'(n_done - d0c), 8'd2);
    chk("b2b_nxfer", 8'(n_xfer - x0c), 8'd16);
    chk("b2b_pop", 8'(p1), 8'd1);
    tick(2);
    chk("queue_empty", 8'(q1.size()), 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/unpacked_serializer.md
# unpacked_serializer

Downstream consumer of the 8-element unpacked array `x [7:0]` carried by interface `I`. It connects through a consumer modport view and captures a snapshot of the array on a start request. It then shifts the snapshot out one bit per accepted transfer over a valid/ready stream, and reports the snapshot's population count. It sits between the array producer and any bit-serial sink: pins, a UART-style framer, or a test collector.

## Interface
Parameters:
- `LSB_FIRST`, default 1: 1 transmits `x[0]` first and `x[7]` last; 0 transmits `x[7]` first and `x[0]` last.

Interface addition:
- Interface `I` gains modport `C ( input x )`.
- This block's array port is `I.C c`.
- Modport `C` is selected both at the port list and at the instance connection, e.g. `.c (u_I.C)`.

Ports:
- `i_clk`  input  1  sole clock; all state updates on rising edge.
- `i_arst_n`  input  1  asynchronous, active-low reset.
- `c`  modport `I.C`  8x1 unpacked  array source; `c.x[i]` is read only when a start is accepted.
- `i_start`  input  1  capture request; honoured only in IDLE.
- `i_ready`  input  1  sink can accept the current bit.
- `o_valid`  output  1  `o_data` holds a bit for transfer.
- `o_data`  output  1  current serial bit.
- `o_last`  output  1  current bit is the 8th bit of the frame.
- `o_busy`  output  1  a frame is in progress (state SHIFT).
- `o_done`  output  1  one-cycle pulse after the final transfer.
- `o_popcnt`  output  4  count of ones in the captured snapshot, range 0..8.

## Operation
- Internal state:
  - FSM with two states, IDLE and SHIFT.
  - 8-bit shadow register `snap`.
  - 3-bit index `idx`.
- Reset, asynchronous on `i_arst_n`=0:
  - FSM goes to IDLE; `snap`=0; `idx`=0.
  - `o_valid`=0, `o_data`=0, `o_last`=0, `o_busy`=0, `o_done`=0, `o_popcnt`=0.
- IDLE with `i_start`=1:
  - `snap[i]` <= `c.x[i]` for i=0..7.
  - `o_popcnt` <= number of ones in `c.x`.
  - `idx` <= 0; FSM goes to SHIFT.
- IDLE with `i_start`=0: all registers hold.
- SHIFT:
  - `o_valid`=1 and `o_busy`=1.
  - `o_data` = `snap[idx]` when `LSB_FIRST`=1, otherwise `snap[7-idx]`.
  - `o_last` = (`idx`==7).
- Transfer: a transfer occurs in any cycle with `o_valid`=1 and `i_ready`=1.
  - When `idx`<7, `idx` increments.
  - When `idx`==7, FSM goes to IDLE, `idx` <= 0, and `o_done` pulses high for the next cycle only.
- Stall: while `o_valid`=1 and `i_ready`=0, `o_data`, `o_last` and `idx` hold.
- `i_start` in SHIFT is ignored. This includes the cycle of the final transfer. It is not queued.
- `o_popcnt` holds its value until the next accepted start. It remains valid after the frame ends.
- Changes on `c.x` after capture have no effect on the frame in progress.
- `o_valid`, `o_busy` and `o_last` are decoded from registered state only. No combinational path exists from `i_ready` or `i_start` to any output.

## Timing
- Start accepted at edge t: `o_valid`=1 from cycle t+1, carrying the first bit.
- Capture latency: 1 cycle. The snapshot is the value of `c.x` sampled at edge t.
- With `i_ready` held high: 8 consecutive transfers in cycles t+1..t+8; `o_last`=1 in cycle t+8; `o_done`=1 and `o_busy`=0 in cycle t+9.
- Minimum start-to-start spacing: 9 cycles. The earliest new start is accepted at edge t+9, the same cycle `o_done` is high.
- Each cycle with `i_ready`=0 extends the frame by exactly one cycle.
- Reset mid-frame:
  - Outputs clear immediately, without waiting for a clock edge.
  - No `o_done` is emitted for the aborted frame.
  - After `i_arst_n` rises, the block is in IDLE and the first edge can accept a start.

## Test plan
- Producer drives `c.x` (x[7]..x[0]) = 1,0,1,1,0,0,1,0; `LSB_FIRST`=1; start pulse; `i_ready`=1 → `o_data` = 0,1,0,0,1,1,0,1 over 8 cycles; `o_last` on the 8th bit only; `o_popcnt`=4; single `o_done` pulse at t+9.
- Same array with `LSB_FIRST`=0 → `o_data` = 1,0,1,1,0,0,1,0; `o_popcnt`=4.
- All ones, with `i_ready` low during cycles t+2..t+4 → bit 1 held for 3 extra cycles; `o_done` at t+12; `o_popcnt`=8.
- Start, then `c.x` flipped to all zeros and `i_start` pulsed again during SHIFT → the original snapshot is streamed unchanged and the second start is ignored. Start at t+9 captures zeros: `o_popcnt`=0, 8 zero bits.
- Assert `i_arst_n`=0 at cycle t+4 of a frame → all outputs 0 immediately; no `o_done`; a start after release produces a complete fresh 8-bit frame.
- Back-to-back frames: start at t and at t+9 with `i_ready`=1 → 16 transfers with exactly one idle cycle between frames; two `o_done` pulses.
